// File: rtl/backtrack_controller.sv
// backtrack_controller: arbitrates trace-table pushes and unwinds the stack to the latest decision on conflict
module backtrack_controller #(
  parameter int NUM_VARIABLE = 128,
  parameter int VARIABLE_INDEXES = 8,
  localparam int DW = $clog2(NUM_VARIABLE + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      dec_req,
  input  logic [VARIABLE_INDEXES:0] dec_var,
  input  logic                      dec_val,
  input  logic                      frc_req,
  input  logic [VARIABLE_INDEXES:0] frc_var,
  input  logic                      frc_val,
  input  logic                      conflict,
  output logic                      dec_ready,
  output logic                      frc_ready,
  output logic                      tt_en,
  output logic                      tt_rw,
  output logic                      tt_reset,
  output logic                      tt_type_in,
  output logic                      tt_val_in,
  output logic [VARIABLE_INDEXES:0] tt_variable,
  input  logic                      tt_type_out,
  input  logic                      tt_val_out,
  input  logic [VARIABLE_INDEXES:0] tt_variable_out,
  output logic                      unassign_valid,
  output logic [VARIABLE_INDEXES:0] unassign_var,
  output logic                      flip_valid,
  output logic [VARIABLE_INDEXES:0] flip_var,
  output logic                      flip_val,
  output logic                      busy,
  output logic                      done,
  output logic                      unsat,
  output logic [DW-1:0]             depth
);
  typedef enum logic [2:0] {INIT, IDLE, POP_REQ, POP_WAIT, PUSH_FLIP, UNSAT} state_t;
  localparam logic [DW-1:0] FULL = DW'(NUM_VARIABLE);
  state_t state, next;
  logic [VARIABLE_INDEXES:0] saved_var;
  logic saved_val;
  logic full;
  assign full = depth >= FULL;
  assign busy = state != IDLE;
  assign unsat = state == UNSAT;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= INIT;
      depth <= '0;
      saved_var <= '0;
      saved_val <= 1'b0;
    end else begin
      state <= next;
      depth <= tt_en && tt_rw ? depth + DW'(1) : state == POP_REQ ? depth - DW'(1) : depth;
      if (flip_valid) begin
        saved_var <= flip_var;
        saved_val <= flip_val;
      end
    end
  always_comb begin
    next = state;
    dec_ready = 1'b0;
    frc_ready = 1'b0;
    tt_en = 1'b0;
    tt_rw = 1'b0;
    tt_reset = 1'b0;
    tt_type_in = 1'b0;
    tt_val_in = 1'b0;
    tt_variable = '0;
    unassign_valid = 1'b0;
    unassign_var = '0;
    flip_valid = 1'b0;
    flip_var = '0;
    flip_val = 1'b0;
    done = 1'b0;
    case (state)
      INIT: begin
        tt_en = 1'b1;
        tt_reset = 1'b1;
        next = IDLE;
      end
      IDLE:
        if (conflict) next = depth == '0 ? UNSAT : POP_REQ;
        else begin
          frc_ready = frc_req && !full;
          dec_ready = dec_req && !frc_req && !full;
          tt_en = frc_ready || dec_ready;
          tt_rw = tt_en;
          tt_type_in = frc_ready;
          tt_val_in = frc_ready ? frc_val : dec_ready && dec_val;
          tt_variable = frc_ready ? frc_var : dec_ready ? dec_var : '0;
        end
      POP_REQ: begin
        tt_en = 1'b1;
        next = POP_WAIT;
      end
      POP_WAIT: begin
        unassign_valid = 1'b1;
        unassign_var = tt_variable_out;
        // a decide entry ends the unwind; its opposite polarity goes back as forced
        if (tt_type_out) next = depth != '0 ? POP_REQ : UNSAT;
        else begin
          flip_valid = 1'b1;
          flip_var = tt_variable_out;
          flip_val = ~tt_val_out;
          next = PUSH_FLIP;
        end
      end
      PUSH_FLIP: begin
        tt_en = 1'b1;
        tt_rw = 1'b1;
        tt_type_in = 1'b1;
        tt_val_in = saved_val;
        tt_variable = saved_var;
        done = 1'b1;
        next = IDLE;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_backtrack_controller.sv
// tb_backtrack_controller: directed vectors plus hand-written backtrack/UNSAT/full/reset sequences against a trace-table stack model
module tb_backtrack_controller;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic dec_req = 1'b0, dec_val = 1'b0, frc_req = 1'b0, frc_val = 1'b0, conflict = 1'b0;
  logic [8:0] dec_var = '0, frc_var = '0;
  logic dec_ready, frc_ready, tt_en, tt_rw, tt_reset, tt_type_in, tt_val_in;
  logic [8:0] tt_variable, unassign_var, flip_var;
  logic tt_type_out, tt_val_out;
  logic [8:0] tt_variable_out;
  logic unassign_valid, flip_valid, flip_val, busy, done, unsat;
  logic [7:0] depth;
  logic [10:0] mem [0:255];
  int sp = 0;
  int passed = 0;
  int total = 0;

  always #5 clock = ~clock;

  backtrack_controller dut (
    .clock(clock), .reset(reset),
    .dec_req(dec_req), .dec_var(dec_var), .dec_val(dec_val),
    .frc_req(frc_req), .frc_var(frc_var), .frc_val(frc_val),
    .conflict(conflict), .dec_ready(dec_ready), .frc_ready(frc_ready),
    .tt_en(tt_en), .tt_rw(tt_rw), .tt_reset(tt_reset),
    .tt_type_in(tt_type_in), .tt_val_in(tt_val_in), .tt_variable(tt_variable),
    .tt_type_out(tt_type_out), .tt_val_out(tt_val_out), .tt_variable_out(tt_variable_out),
    .unassign_valid(unassign_valid), .unassign_var(unassign_var),
    .flip_valid(flip_valid), .flip_var(flip_var), .flip_val(flip_val),
    .busy(busy), .done(done), .unsat(unsat), .depth(depth)
  );

  // trace-table stand-in: synchronous clear, push, and registered pop
  always @(posedge clock)
    if (tt_en) begin
      if (tt_reset) sp <= 0;
      else if (tt_rw) begin
        mem[sp] <= {tt_type_in, tt_val_in, tt_variable};
        sp <= sp + 1;
      end else if (sp > 0) begin
        {tt_type_out, tt_val_out, tt_variable_out} <= mem[sp-1];
        sp <= sp - 1;
      end
    end

  typedef struct {
    logic dreq; logic [8:0] dvar; logic dval;
    logic freq; logic [8:0] fvar; logic fval;
    logic edr; logic efr; logic een; logic etype; logic eval; logic [8:0] evar; logic [7:0] edep;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    #3;
    chk("rst_busy", busy, 1);
    chk("rst_tt_reset", tt_reset, 1);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("post_rst_idle", busy, 0);
    chk("post_rst_depth", depth, 0);
  endtask

  task automatic push(input logic frc, input logic [8:0] v, input logic val);
    @(negedge clock);
    if (frc) begin frc_req = 1'b1; frc_var = v; frc_val = val; end
    else begin dec_req = 1'b1; dec_var = v; dec_val = val; end
    #1;
    chk(frc ? "push_frc_ready" : "push_dec_ready", frc ? frc_ready : dec_ready, 1);
    @(posedge clock);
    #1;
    frc_req = 1'b0;
    dec_req = 1'b0;
  endtask

  logic [8:0] exp_un [1:8];

  initial begin
    tbl[0] = '{1'b1, 9'd5, 1'b0, 1'b1, 9'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 9'd9, 8'd1};
    tbl[1] = '{1'b1, 9'd5, 1'b1, 1'b0, 9'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 9'd5, 8'd2};
    tbl[2] = '{1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 8'd2};
    tbl[3] = '{1'b0, 9'd0, 1'b0, 1'b1, 9'h1FF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 9'h1FF, 8'd3};
    tbl[4] = '{1'b1, 9'h100, 1'b0, 1'b0, 9'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9'h100, 8'd4};

    // reset held 3 cycles, then one INIT cycle, then IDLE
    repeat (3) @(posedge clock);
    #1;
    chk("init_tt_reset", tt_reset, 1);
    chk("init_busy", busy, 1);
    chk("init_depth", depth, 0);
    chk("init_unsat", unsat, 0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("first_cycle_tt_reset", tt_reset, 1);
    @(posedge clock);
    #1;
    chk("idle_tt_reset", tt_reset, 0);
    chk("idle_busy", busy, 0);
    chk("idle_depth", depth, 0);
    chk("idle_unsat", unsat, 0);

    foreach (tbl[i]) begin
      @(negedge clock);
      dec_req = tbl[i].dreq; dec_var = tbl[i].dvar; dec_val = tbl[i].dval;
      frc_req = tbl[i].freq; frc_var = tbl[i].fvar; frc_val = tbl[i].fval;
      #1;
      chk($sformatf("v%0d_dec_ready", i), dec_ready, tbl[i].edr);
      chk($sformatf("v%0d_frc_ready", i), frc_ready, tbl[i].efr);
      chk($sformatf("v%0d_tt_en", i), tt_en, tbl[i].een);
      chk($sformatf("v%0d_tt_rw", i), tt_rw, tbl[i].een);
      if (tbl[i].een) begin
        chk($sformatf("v%0d_type", i), tt_type_in, tbl[i].etype);
        chk($sformatf("v%0d_val", i), tt_val_in, tbl[i].eval);
        chk($sformatf("v%0d_var", i), tt_variable, tbl[i].evar);
      end
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_depth", i), depth, tbl[i].edep);
    end
    dec_req = 1'b0;
    frc_req = 1'b0;
    chk("tbl_entry0", mem[0], {1'b1, 1'b1, 9'd9});
    chk("tbl_entry1", mem[1], {1'b0, 1'b1, 9'd5});

    // backtrack: decide(3,T), forced(7,F), forced(4,T); conflict blocks a concurrent push
    do_reset();
    push(1'b0, 9'd3, 1'b1);
    push(1'b1, 9'd7, 1'b0);
    push(1'b1, 9'd4, 1'b1);
    chk("bt_depth3", depth, 3);
    @(negedge clock);
    conflict = 1'b1;
    dec_req = 1'b1;
    dec_var = 9'd11;
    #1;
    chk("conf_dec_ready", dec_ready, 0);
    chk("conf_tt_en", tt_en, 0);
    exp_un[2] = 9'd4; exp_un[4] = 9'd7; exp_un[6] = 9'd3;
    @(posedge clock);
    for (int c = 1; c <= 8; c++) begin
      #1;
      chk($sformatf("bt_c%0d_unassign", c), unassign_valid, (c == 2 || c == 4 || c == 6) ? 1 : 0);
      if (c == 2 || c == 4 || c == 6) chk($sformatf("bt_c%0d_unvar", c), unassign_var, exp_un[c]);
      chk($sformatf("bt_c%0d_flip", c), flip_valid, c == 6 ? 1 : 0);
      chk($sformatf("bt_c%0d_done", c), done, c == 7 ? 1 : 0);
      chk($sformatf("bt_c%0d_busy", c), busy, c == 8 ? 0 : 1);
      chk($sformatf("bt_c%0d_dec_ready", c), dec_ready, 0);
      if (c == 6) begin
        chk("bt_flip_var", flip_var, 3);
        chk("bt_flip_val", flip_val, 0);
      end
      if (c == 1) begin
        conflict = 1'b0;
        dec_req = 1'b0;
      end
      @(posedge clock);
    end
    #1;
    chk("bt_depth_after", depth, 1);
    chk("bt_model_sp", sp, 1);
    chk("bt_top_entry", mem[0], {1'b1, 1'b0, 9'd3});

    // drain to UNSAT with only forced entries
    do_reset();
    push(1'b1, 9'd2, 1'b1);
    push(1'b1, 9'd6, 1'b0);
    @(negedge clock);
    conflict = 1'b1;
    exp_un[2] = 9'd6; exp_un[4] = 9'd2;
    @(posedge clock);
    for (int c = 1; c <= 5; c++) begin
      #1;
      conflict = 1'b0;
      chk($sformatf("un_c%0d_unassign", c), unassign_valid, (c == 2 || c == 4) ? 1 : 0);
      if (c == 2 || c == 4) chk($sformatf("un_c%0d_unvar", c), unassign_var, exp_un[c]);
      chk($sformatf("un_c%0d_flip", c), flip_valid, 0);
      chk($sformatf("un_c%0d_unsat", c), unsat, c == 5 ? 1 : 0);
      @(posedge clock);
    end
    @(negedge clock);
    dec_req = 1'b1;
    frc_req = 1'b1;
    conflict = 1'b1;
    #1;
    chk("unsat_frc_ready", frc_ready, 0);
    chk("unsat_dec_ready", dec_ready, 0);
    chk("unsat_tt_en", tt_en, 0);
    repeat (3) @(posedge clock);
    #1;
    chk("unsat_sticky", unsat, 1);
    chk("unsat_busy", busy, 1);
    chk("unsat_depth", depth, 0);
    dec_req = 1'b0;
    frc_req = 1'b0;
    conflict = 1'b0;

    // conflict on an empty stack goes straight to UNSAT
    do_reset();
    @(negedge clock);
    conflict = 1'b1;
    @(posedge clock);
    #1;
    conflict = 1'b0;
    chk("empty_conf_unsat", unsat, 1);
    chk("empty_conf_unassign", unassign_valid, 0);

    // fill to capacity
    do_reset();
    for (int i = 0; i < 128; i++) push(i[0], 9'(i), i[1]);
    chk("full_depth", depth, 128);
    @(negedge clock);
    dec_req = 1'b1;
    #1;
    chk("full_dec_ready", dec_ready, 0);
    chk("full_dec_tt_en", tt_en, 0);
    frc_req = 1'b1;
    #1;
    chk("full_frc_ready", frc_ready, 0);
    @(posedge clock);
    #1;
    chk("full_depth_hold", depth, 128);
    dec_req = 1'b0;
    frc_req = 1'b0;

    // reset while in POP_WAIT
    @(negedge clock);
    conflict = 1'b1;
    @(posedge clock);
    #1;
    conflict = 1'b0;
    @(posedge clock);
    #1;
    chk("mid_unassign_before", unassign_valid, 1);
    chk("mid_unvar_before", unassign_var, 127);
    chk("mid_depth_before", depth, 127);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_busy", busy, 1);
    chk("mid_tt_reset", tt_reset, 1);
    chk("mid_depth", depth, 0);
    chk("mid_unassign", unassign_valid, 0);
    chk("mid_flip", flip_valid, 0);
    chk("mid_done", done, 0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("mid_model_cleared", sp, 0);
    chk("mid_idle", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
